i2s_tx_10xe_axis_aud_fifo: RTL and testbench

- Parametrised AXI-Stream audio ingress buffer in front of the I2S transmitter core.
- Accepts multi-channel audio samples on a slave AXI-Stream port, checks the channel-ID sequence, and buffers samples in a DEPTH-entry FIFO.
- Presents samples first-word-fall-through on a master AXI-Stream port to the serialiser.
- Generalises the fixed 32-bit/3-bit-ID stereo stream to configurable data width, ID width, depth and channel count.

---
 rtl/i2s_tx_10xe_axis_aud_fifo.sv | 125 ++++++++++++
 tb/tb_i2s_tx_10xe_axis_aud_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_10xe_axis_aud_fifo.sv
// rtl/i2s_tx_10xe_axis_aud_fifo.sv - AXI-Stream audio ingress FIFO with channel-sequence checking
// Buffers samples first-word-fall-through for the I2S serialiser.
module i2s_tx_10xe_axis_aud_fifo #(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 3,
  parameter int DEPTH       = 8,
  parameter int NUM_CH      = 2,
  parameter int DROP_BAD_ID = 1
) (
  input  logic                       s_axis_aud_aclk,
  input  logic                       s_axis_aud_aresetn,
  input  logic [DATA_W-1:0]          s_axis_aud_tdata,
  input  logic [ID_W-1:0]            s_axis_aud_tid,
  input  logic                       s_axis_aud_tvalid,
  output logic                       s_axis_aud_tready,
  output logic [DATA_W-1:0]          m_axis_aud_tdata,
  output logic [ID_W-1:0]            m_axis_aud_tid,
  output logic                       m_axis_aud_tvalid,
  input  logic                       m_axis_aud_tready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       seq_err,
  input  logic                       seq_err_clr,
  output logic [7:0]                 err_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ID_W-1:0]   mem_id   [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic              s_tready_q, m_tvalid_q;
  logic [DATA_W-1:0] m_tdata_q, head_data;
  logic [ID_W-1:0]   m_tid_q, head_id;
  logic [ID_W-1:0]   exp_ch_q, exp_ch_d;
  logic              seq_err_q, seq_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              accept, pop, wr_en, id_bad, seq_hit;

  function automatic logic [ID_W-1:0] next_ch(input logic [ID_W-1:0] c);
    return (c == ID_W'(NUM_CH - 1)) ? '0 : c + ID_W'(1);
  endfunction

  always_comb begin
    accept  = s_axis_aud_tvalid && s_tready_q;
    pop     = m_tvalid_q && m_axis_aud_tready;
    id_bad  = {1'b0, s_axis_aud_tid} >= (ID_W+1)'(NUM_CH);
    wr_en   = accept && !((DROP_BAD_ID != 0) && id_bad);
    seq_hit = accept && (s_axis_aud_tid != exp_ch_q);

    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    fill_d = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + 1'b1;
    else if (!wr_en && pop) fill_d = fill_q - 1'b1;

    // A write landing on the next read slot can only happen when the FIFO drains to empty.
    if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
      head_data = s_axis_aud_tdata;
      head_id   = s_axis_aud_tid;
    end else begin
      head_data = mem_data[rd_ptr_d];
      head_id   = mem_id[rd_ptr_d];
    end

    exp_ch_d = exp_ch_q;
    if (accept && !id_bad) exp_ch_d = next_ch(s_axis_aud_tid);

    seq_err_d = seq_err_q;
    err_cnt_d = err_cnt_q;
    if (seq_err_clr) begin
      seq_err_d = seq_hit;
      err_cnt_d = seq_hit ? 8'd1 : 8'd0;
    end else if (seq_hit) begin
      seq_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge s_axis_aud_aclk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= s_axis_aud_tdata;
      mem_id[wr_ptr_q]   <= s_axis_aud_tid;
    end
  end

  always_ff @(posedge s_axis_aud_aclk or negedge s_axis_aud_aresetn) begin
    if (!s_axis_aud_aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= '0;
      exp_ch_q   <= '0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      s_tready_q <= fill_d < (AW+1)'(DEPTH);
      m_tvalid_q <= fill_d != '0;
      if (fill_d != '0) begin
        m_tdata_q <= head_data;
        m_tid_q   <= head_id;
      end
      exp_ch_q   <= exp_ch_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_axis_aud_tready = s_tready_q;
  assign m_axis_aud_tvalid = m_tvalid_q;
  assign m_axis_aud_tdata  = m_tdata_q;
  assign m_axis_aud_tid    = m_tid_q;
  assign fill_level        = fill_q;
  assign seq_err           = seq_err_q;
  assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_i2s_tx_10xe_axis_aud_fifo.sv
// tb/tb_i2s_tx_10xe_axis_aud_fifo.sv - directed self-checking bench for the audio ingress FIFO
module tb_i2s_tx_10xe_axis_aud_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_tdata;
  logic [2:0]  s_tid;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [2:0]  m_tid;
  logic        m_tvalid;
  logic        m_tready;
  logic [3:0]  fill;
  logic        seq_err;
  logic        seq_err_clr;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int acc;
  logic hit;

  always #5 clk = ~clk;

  i2s_tx_10xe_axis_aud_fifo #(
    .DATA_W(32), .ID_W(3), .DEPTH(8), .NUM_CH(2), .DROP_BAD_ID(1)
  ) dut (
    .s_axis_aud_aclk   (clk),
    .s_axis_aud_aresetn(resetn),
    .s_axis_aud_tdata  (s_tdata),
    .s_axis_aud_tid    (s_tid),
    .s_axis_aud_tvalid (s_tvalid),
    .s_axis_aud_tready (s_tready),
    .m_axis_aud_tdata  (m_tdata),
    .m_axis_aud_tid    (m_tid),
    .m_axis_aud_tvalid (m_tvalid),
    .m_axis_aud_tready (m_tready),
    .fill_level        (fill),
    .seq_err           (seq_err),
    .seq_err_clr       (seq_err_clr),
    .err_cnt           (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [2:0] id);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tid    = id;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic clr_pulse;
    seq_err_clr = 1'b1;
    tick();
    seq_err_clr = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; s_tdata = '0; s_tid = '0; s_tvalid = 1'b0;
    m_tready = 1'b0; seq_err_clr = 1'b0;
    repeat (3) tick();
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_fill", fill, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_tdata", m_tdata, 0);
    resetn = 1'b1;
    tick();
    check("rel_tready", s_tready, 1);
    check("rel_tvalid", m_tvalid, 0);

    // streaming with downstream always ready
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hA0 + i; s_tid = 3'(i % 2);
      tick();
      check("t1_valid", m_tvalid, 1);
      check("t1_data", m_tdata, 32'hA0 + i);
      check("t1_tid", m_tid, i % 2);
      check("t1_fill", fill, 1);
    end
    s_tvalid = 1'b0;
    tick();
    check("t1_empty_fill", fill, 0);
    check("t1_empty_valid", m_tvalid, 0);
    check("t1_seq_err", seq_err, 0);

    // fill to full with downstream stalled
    m_tready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1; s_tdata = 32'hB0 + acc; s_tid = 3'(acc % 2);
      hit = s_tready;
      tick();
      if (hit) acc++;
    end
    s_tvalid = 1'b0;
    check("t2_accepted", acc, 8);
    check("t2_fill", fill, 8);
    check("t2_tready", s_tready, 0);
    check("t2_hold_data", m_tdata, 32'hB0);
    m_tready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("t2_drain_data", m_tdata, 32'hB0 + j);
      check("t2_drain_tid", m_tid, j % 2);
      tick();
      if (j == 0) check("t2_tready_back", s_tready, 1);
    end
    check("t2_fill_end", fill, 0);

    // steady-state write+pop at fill 4
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hC0 + i, 3'(i % 2));
    check("t3_fill_pre", fill, 4);
    m_tready = 1'b1; s_tvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      s_tdata = 32'hC4 + k; s_tid = 3'(k % 2);
      check("t3_head", m_tdata, 32'hC0 + k);
      tick();
      check("t3_fill", fill, 4);
    end
    s_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t3_tail", m_tdata, 32'hC0 + 20 + k);
      tick();
    end
    check("t3_fill_end", fill, 0);
    check("t3_seq_err", seq_err, 0);

    // sequence error 0,0,1 then clear
    send(32'h10, 3'd0);
    check("t4_clean_first", seq_err, 0);
    send(32'h11, 3'd0);
    check("t4_seq_err", seq_err, 1);
    check("t4_err_cnt", err_cnt, 1);
    send(32'h12, 3'd1);
    check("t4_third_cnt", err_cnt, 1);
    clr_pulse();
    check("t4_clr_err", seq_err, 0);
    check("t4_clr_cnt", err_cnt, 0);
    send(32'h13, 3'd1);
    check("t4_err_again", err_cnt, 1);
    seq_err_clr = 1'b1;
    send(32'h14, 3'd1);
    seq_err_clr = 1'b0;
    check("t4_clr_vs_err_flag", seq_err, 1);
    check("t4_clr_vs_err_cnt", err_cnt, 1);
    clr_pulse();
    check("t4_clr2_cnt", err_cnt, 0);
    check("t4_fill", fill, 0);

    // bad tid dropped but counted
    m_tready = 1'b0;
    send(32'hD0, 3'd0);
    check("t5_fill1", fill, 1);
    send(32'hD1, 3'd5);
    check("t5_fill_drop", fill, 1);
    send(32'hD2, 3'd1);
    check("t5_fill_peak", fill, 2);
    check("t5_err_cnt", err_cnt, 1);
    m_tready = 1'b1;
    check("t5_out0_data", m_tdata, 32'hD0);
    check("t5_out0_tid", m_tid, 0);
    tick();
    check("t5_out1_data", m_tdata, 32'hD2);
    check("t5_out1_tid", m_tid, 1);
    tick();
    check("t5_empty", m_tvalid, 0);
    clr_pulse();

    // error counter saturation
    s_tvalid = 1'b1; s_tid = 3'd7; s_tdata = 32'hEE;
    repeat (260) tick();
    s_tvalid = 1'b0;
    check("sat_err_cnt", err_cnt, 255);
    check("sat_fill", fill, 0);
    clr_pulse();

    // mid-operation reset
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'hE0 + i, 3'(i % 2));
    check("t6_fill_pre", fill, 5);
    check("t6_valid_pre", m_tvalid, 1);
    resetn = 1'b0;
    #1;
    check("t6_rst_fill", fill, 0);
    check("t6_rst_valid", m_tvalid, 0);
    check("t6_rst_tready", s_tready, 0);
    check("t6_rst_tdata", m_tdata, 0);
    check("t6_rst_tid", m_tid, 0);
    tick();
    resetn = 1'b1;
    tick();
    check("t6_rel_tready", s_tready, 1);
    check("t6_rel_valid", m_tvalid, 0);
    check("t6_rel_fill", fill, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
